// File: rtl/data_sram_resp_if.sv
// Request/response bus between the EXE/MEM stages and the data SRAM.
// The master side issues requests and consumes read data and debug counters.
interface data_sram_resp_if;

    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        rdata_valid;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  rdata_valid,
        input  rd_cnt,
        input  wr_cnt
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output rdata_valid,
        output rd_cnt,
        output wr_cnt
    );

endinterface

// File: rtl/data_sram_resp.sv
// Single-port synchronous data RAM serving loads and stores from the EXE stage.
// Read data travels through a LATENCY-deep {valid, data} pipeline so the MEM
// stage sees it a fixed number of cycles after the request. Accepted reads and
// writes are counted for debug visibility. LATENCY must lie in 1..4.
module data_sram_resp #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned LATENCY = 1
) (
    input  logic            clk,
    input  logic            resetn,
    data_sram_resp_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Storage array; deliberately never reset so contents survive resetn.
    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic              read_req;
    logic              write_req;
    logic [31:0]       rd_word;

    logic              pipe_valid_q [LATENCY];
    logic              pipe_valid_d [LATENCY];
    logic [31:0]       pipe_data_q  [LATENCY];
    logic [31:0]       pipe_data_d  [LATENCY];

    logic [31:0]       rd_cnt_q;
    logic [31:0]       rd_cnt_d;
    logic [31:0]       wr_cnt_q;
    logic [31:0]       wr_cnt_d;

    // Byte offset and address bits above the array size are intentionally
    // dropped, so the word index wraps modulo the array depth.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

    // Classify the request and fetch the addressed word for a possible read.
    always_comb begin
        word_idx  = bus.data_sram_addr[ADDR_W+1:2];
        read_req  = bus.data_sram_en & ~(|bus.data_sram_we);
        write_req = bus.data_sram_en & (|bus.data_sram_we);
        rd_word   = mem[word_idx];
    end

    // Byte-masked store; a store presented while in reset is dropped.
    always_ff @(posedge clk) begin
        if (resetn && write_req) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.data_sram_we[b]) begin
                    mem[word_idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures the array word on the request edge and
    // each later stage takes the previous one. A stage's data only changes when
    // valid data arrives, so the last stage holds the most recent read result.
    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        logic        stage_valid_in;
        logic [31:0] stage_data_in;

        if (s == 0) begin : g_head
            assign stage_valid_in = read_req;
            assign stage_data_in  = rd_word;
        end else begin : g_tail
            assign stage_valid_in = pipe_valid_q[s-1];
            assign stage_data_in  = pipe_data_q[s-1];
        end

        // Next-state of this stage: advance every cycle, load data only when valid.
        always_comb begin
            pipe_valid_d[s] = stage_valid_in;
            pipe_data_d[s]  = pipe_data_q[s];
            if (stage_valid_in) begin
                pipe_data_d[s] = stage_data_in;
            end
        end

        // Stage register; reset discards anything in flight.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                pipe_valid_q[s] <= 1'b0;
                pipe_data_q[s]  <= '0;
            end else begin
                pipe_valid_q[s] <= pipe_valid_d[s];
                pipe_data_q[s]  <= pipe_data_d[s];
            end
        end
    end

    // Access counters, wrapping naturally at 2**32.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (read_req) begin
            rd_cnt_d = rd_cnt_q + 32'd1;
        end
        if (write_req) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    // Counter registers; a request seen during reset is not counted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign bus.data_sram_rdata = pipe_data_q[LATENCY-1];
    assign bus.rdata_valid     = pipe_valid_q[LATENCY-1];
    assign bus.rd_cnt          = rd_cnt_q;
    assign bus.wr_cnt          = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp. Three instances with LATENCY 1, 2
// and 3 receive identical stimulus; a behavioural model (word map plus a
// per-latency table of when each read result is due) predicts every output.
module tb_data_sram_resp;

    localparam int ADDR_W = 14;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    data_sram_resp_if ifc1 ();
    data_sram_resp_if ifc2 ();
    data_sram_resp_if ifc3 ();

    data_sram_resp #(.ADDR_W(ADDR_W), .LATENCY(1)) dut_l1 (.clk(clk), .resetn(resetn), .bus(ifc1.slave));
    data_sram_resp #(.ADDR_W(ADDR_W), .LATENCY(2)) dut_l2 (.clk(clk), .resetn(resetn), .bus(ifc2.slave));
    data_sram_resp #(.ADDR_W(ADDR_W), .LATENCY(3)) dut_l3 (.clk(clk), .resetn(resetn), .bus(ifc3.slave));

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mem_model [int];
    int          lat [3] = '{1, 2, 3};
    logic        due_v [3][8];
    logic [31:0] due_d [3][8];
    logic        exp_valid [3];
    logic [31:0] exp_rdata [3];
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    int          cyc = 0;

    // Count a comparison and report any difference.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int wordIdx(input logic [31:0] a);
        return int'((a >> 2) % (32'd1 << ADDR_W));
    endfunction

    // Advance the model by one clock edge using the request that was presented.
    task automatic updateModel(input logic en, input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic rstn);
        int          idx;
        logic [31:0] word;
        idx = wordIdx(addr);
        if (!rstn) begin
            for (int k = 0; k < 3; k++) begin
                for (int s = 0; s < 8; s++) due_v[k][s] = 1'b0;
                exp_valid[k] = 1'b0;
                exp_rdata[k] = 32'h0;
            end
            exp_rd = 32'h0;
            exp_wr = 32'h0;
        end else begin
            if (en && we != 4'h0) begin
                word = mem_model.exists(idx) ? mem_model[idx] : 32'h0;
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) word[8*b +: 8] = wdata[8*b +: 8];
                end
                mem_model[idx] = word;
                exp_wr = exp_wr + 32'd1;
            end else if (en) begin
                word = mem_model.exists(idx) ? mem_model[idx] : 32'h0;
                for (int k = 0; k < 3; k++) begin
                    due_v[k][(cyc + lat[k] - 1) % 8] = 1'b1;
                    due_d[k][(cyc + lat[k] - 1) % 8] = word;
                end
                exp_rd = exp_rd + 32'd1;
            end
            for (int k = 0; k < 3; k++) begin
                if (due_v[k][cyc % 8]) begin
                    exp_valid[k] = 1'b1;
                    exp_rdata[k] = due_d[k][cyc % 8];
                    due_v[k][cyc % 8] = 1'b0;
                end else begin
                    exp_valid[k] = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    task automatic checkDut(input int k, input logic [31:0] rdata, input logic valid,
                            input logic [31:0] rdc, input logic [31:0] wrc);
        checkOutput($sformatf("L%0d rdata_valid c%0d", lat[k], cyc), {31'd0, valid}, {31'd0, exp_valid[k]});
        checkOutput($sformatf("L%0d rdata c%0d", lat[k], cyc), rdata, exp_rdata[k]);
        checkOutput($sformatf("L%0d rd_cnt c%0d", lat[k], cyc), rdc, exp_rd);
        checkOutput($sformatf("L%0d wr_cnt c%0d", lat[k], cyc), wrc, exp_wr);
    endtask

    // Drive one cycle of stimulus into all instances, then check all outputs.
    task automatic applyStimulus(input logic en, input logic [3:0] we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic rstn);
        resetn               = rstn;
        ifc1.data_sram_en    = en;  ifc2.data_sram_en    = en;  ifc3.data_sram_en    = en;
        ifc1.data_sram_we    = we;  ifc2.data_sram_we    = we;  ifc3.data_sram_we    = we;
        ifc1.data_sram_addr  = addr; ifc2.data_sram_addr = addr; ifc3.data_sram_addr = addr;
        ifc1.data_sram_wdata = wdata; ifc2.data_sram_wdata = wdata; ifc3.data_sram_wdata = wdata;
        @(posedge clk);
        updateModel(en, we, addr, wdata, rstn);
        #1;
        checkDut(0, ifc1.data_sram_rdata, ifc1.rdata_valid, ifc1.rd_cnt, ifc1.wr_cnt);
        checkDut(1, ifc2.data_sram_rdata, ifc2.rdata_valid, ifc2.rd_cnt, ifc2.wr_cnt);
        checkDut(2, ifc3.data_sram_rdata, ifc3.rdata_valid, ifc3.rd_cnt, ifc3.wr_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        int          vcount;
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic        rstn;

        for (int k = 0; k < 3; k++) begin
            for (int s = 0; s < 8; s++) due_v[k][s] = 1'b0;
        end

        $display("[TB] reset");
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("reset rd_cnt", ifc3.rd_cnt, 32'd0);
        checkOutput("reset valid", {31'd0, ifc3.rdata_valid}, 32'd0);

        $display("[TB] store then load");
        applyStimulus(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1);
        checkOutput("t1 L1 data", ifc1.data_sram_rdata, 32'hDEAD_BEEF);
        checkOutput("t1 L1 valid", {31'd0, ifc1.rdata_valid}, 32'd1);
        checkOutput("t1 wr_cnt", ifc1.wr_cnt, 32'd1);
        checkOutput("t1 rd_cnt", ifc1.rd_cnt, 32'd1);
        idle(3);

        $display("[TB] byte enables");
        applyStimulus(1'b1, 4'hF, 32'h0000_0040, 32'h1122_3344, 1'b1);
        applyStimulus(1'b1, 4'b0101, 32'h0000_0040, 32'hAABB_CCDD, 1'b1);
        applyStimulus(1'b1, 4'h0, 32'h0000_0040, 32'h0, 1'b1);
        checkOutput("t2 merged", ifc1.data_sram_rdata, 32'h11BB_33DD);
        idle(3);

        $display("[TB] streaming");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'hF, 32'(i * 4), 32'hA0A0_0000 + 32'(i), 1'b1);
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b1);
            vcount += int'(ifc2.rdata_valid);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
            vcount += int'(ifc2.rdata_valid);
        end
        checkOutput("t3 L2 valid count", 32'(vcount), 32'd4);
        checkOutput("t3 L2 last data", ifc2.data_sram_rdata, 32'hA0A0_0003);

        $display("[TB] wrap and alignment");
        applyStimulus(1'b1, 4'hF, 32'h0001_0000, 32'h5A5A_5A5A, 1'b1);
        applyStimulus(1'b1, 4'h0, 32'h0000_0003, 32'h0, 1'b1);
        checkOutput("t4 wrap", ifc1.data_sram_rdata, 32'h5A5A_5A5A);
        idle(3);

        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
            checkOutput("t5 L3 no valid", {31'd0, ifc3.rdata_valid}, 32'd0);
        end
        checkOutput("t5 L3 rdata", ifc3.data_sram_rdata, 32'd0);
        checkOutput("t5 rd_cnt", ifc3.rd_cnt, 32'd0);
        applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1);
        idle(2);
        checkOutput("t5 L3 after reset", ifc3.data_sram_rdata, 32'hDEAD_BEEF);

        $display("[TB] idle and reset gating");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'hF, 32'h0000_0100, 32'h0, 1'b1);
        checkOutput("t6 wr_cnt", ifc1.wr_cnt, 32'd0);
        applyStimulus(1'b1, 4'hF, 32'h0000_0100, 32'h1234_5678, 1'b0);
        applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0, 1'b1);
        idle(2);
        checkOutput("t6 L3 unchanged", ifc3.data_sram_rdata, 32'hDEAD_BEEF);
        checkOutput("t6 wr_cnt after", ifc3.wr_cnt, 32'd0);

        $display("[TB] random");
        for (int i = 0; i < 128; i++) begin
            addr = (32'(i) << 2) | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 3)) << 16);
            applyStimulus(1'b1, 4'hF, addr, $urandom, 1'b1);
        end
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            addr = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3))
                   | (32'($urandom_range(0, 65535)) << 16);
            rstn = ($urandom_range(0, 49) != 0);
            applyStimulus(en, we, addr, $urandom, rstn);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
